// File: rtl/ifetch_unit_pkg.sv
// Shared constants, state encoding and buffer entry type for the instruction fetch unit.
package ifetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam int          FIFO_DEPTH       = 2;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
// Flush has priority over push and pop; push and pop together keep the count.
module fetch_fifo
    import ifetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [FIFO_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage is pure data and carries no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues word fetches to a synchronous instruction memory,
// buffers responses in a two-entry FIFO and hands them to decode, with redirect support.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0]  pc_p0;
    logic         vld_p1;
    logic [31:0]  req_pc_p1;
    logic [31:0]  last_pc_q;

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    fetch_entry_t fifo_wdata;
    fetch_entry_t fifo_head;

    logic         pop;
    logic [1:0]   fifo_count;
    logic [1:0]   occupancy;
    logic [1:0]   occ_after_pop;

    assign pop           = id_valid && id_ready;
    assign fifo_count    = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occupancy     = fifo_count + {1'b0, vld_p1};
    assign occ_after_pop = occupancy - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Only request when the word returning next cycle is guaranteed a FIFO slot.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                imem_req = !redirect && (occ_after_pop < 2'd2);
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Stage 0 -> 1: fetch PC and the in-flight request marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0     <= BOOT_PC;
            vld_p1    <= 1'b0;
            last_pc_q <= BOOT_PC;
        end else begin
            if (redirect) begin
                pc_p0 <= align_pc(redirect_pc);
            end else if (imem_req) begin
                pc_p0 <= pc_p0 + PC_INC;
            end
            vld_p1    <= imem_req;
            last_pc_q <= id_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            req_pc_p1 <= pc_p0;
        end
    end

    assign imem_addr = pc_p0;

    // Stage 1 -> 2: memory response enters the buffer unless a redirect squashes it
    assign fifo_push  = vld_p1 && !redirect;
    assign fifo_wdata = '{pc: req_pc_p1, instr: imem_rdata};

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign id_valid = !fifo_empty;
    assign id_instr = id_valid ? fifo_head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? fifo_head.pc : last_pc_q;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request this cycle.
REQ-005 imem_addr  output  32  word-aligned fetch address, bits [1:0] always 2'b00.
REQ-006 imem_rdata  input  32  instruction word, valid exactly one cycle after the cycle imem_req was high (synchronous BRAM read).
REQ-007 id_valid  output  1  id_instr and id_pc hold a fetched instruction.
REQ-008 id_ready  input  1  decode/immediate stage accepts the instruction this cycle.
REQ-009 id_instr  output  32  instruction word to decoder and immediate generator.
REQ-010 id_pc  output  32  PC of id_instr.
REQ-011 redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-012 redirect_pc  input  32  target PC; bits [1:0] ignored and treated as 2'b00.

Function
REQ-013 FSM states: S_BOOT, S_RUN; S_BOOT -> S_RUN on the first edge after rst deasserts; no exit from S_RUN except rst.
REQ-014 Handshake: an instruction is consumed on an edge where id_valid and id_ready are both high.
REQ-015 Output buffer: 2-entry FIFO of {pc, instr}; id_valid = FIFO not empty; id_instr/id_pc = head entry.
REQ-016 When id_valid is low, id_instr = 32'h0000_0013 (NOP) and id_pc holds its last value.
REQ-017 inflight = imem_req registered from the previous cycle; occupancy = FIFO count + inflight.
REQ-018 imem_req = S_RUN and not redirect and (occupancy - pop) < 2, where pop = consume this cycle.
REQ-019 imem_addr = pc_q; on each edge with imem_req high, pc_q <= pc_q + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-020 When inflight is high and not squashed, {pc of request, imem_rdata} is written to the FIFO on that edge.
REQ-021 Simultaneous FIFO write and pop: both take effect; count unchanged.
REQ-022 Steady state with id_ready held high: one instruction consumed per cycle, no bubbles.
REQ-023 Redirect on edge N: FIFO emptied (head counted as consumed if id_ready high), in-flight response squashed, pc_q <= {redirect_pc[31:2],2'b00}, no request in cycle N.
REQ-024 After redirect in cycle N: request for target in cycle N+1, id_valid with target in cycle N+3.
REQ-025 Redirect in consecutive cycles: last one wins; earlier targets never reach id_valid.
REQ-026 Redirect during S_BOOT: pc_q updated; first fetch uses redirect target.
REQ-027 First fetch: imem_req high in cycle 1 after S_BOOT exit, id_valid high in cycle 3.
REQ-028 FIFO never overflows; a write when full is a design error (assertion in bench).

Reset
REQ-029 On rst: state S_BOOT, pc_q = RESET_PC, FIFO empty, inflight = 0.
REQ-030 Output reset values: imem_req 0, imem_addr RESET_PC, id_valid 0, id_instr 32'h0000_0013, id_pc RESET_PC.
REQ-031 rst mid-operation takes effect immediately (asynchronous); the pending imem_rdata is discarded.

Structure
REQ-032 Shared package holds: NOP constant 32'h0000_0013, state encoding, default RESET_PC, PC increment 4.
REQ-033 One sub-module, fetch_fifo: 2-entry {pc, instr} FIFO with push/pop/flush, full/empty flags.

Verification
REQ-034 Reset release, id_ready=1, memory returns addr^32'hA5A5_0000 -> requests at 0,4,8,...; id_valid from cycle 3; one instruction per cycle in order.
REQ-035 id_ready=0 for 5 cycles from steady state -> at most 2 buffered, imem_req low while full, no loss/duplication on resume.
REQ-036 redirect=1 with redirect_pc=32'h0000_0102 -> next imem_addr 32'h0000_0100; old FIFO/in-flight words never presented; target valid 3 cycles later.
REQ-037 redirect in two consecutive cycles (0x40 then 0x80) -> only 0x80 stream presented.
REQ-038 RESET_PC=32'hFFFF_FFF8, free run -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst asserted mid-stream with FIFO full -> all outputs at reset values immediately; restart from RESET_PC.
